// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: the machine word, the fetch FSM states and the
// bubble encoding used by both fetch and decode.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // sll $0,$0,0
  localparam word_t NOP_WORD = 32'h0000_0000;

  // Sequential PC increment; wraps naturally at 2^32.
  function automatic word_t pc_inc(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_registers.sv
// IF/ID pipeline latch: flush inserts a bubble, hold freezes the contents,
// load captures a fetched instruction; otherwise a bubble is inserted.
module fetch_registers
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] pcinc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] PCIncOUT,
  output logic [31:0] InstructionOUT,
  output logic        validOUT
);

  word_t pcinc_reg;
  word_t instr_reg;
  logic  valid_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pcinc_reg <= '0;
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (flush) begin
      pcinc_reg <= '0;
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (hold) begin
      pcinc_reg <= pcinc_reg;
      instr_reg <= instr_reg;
      valid_reg <= valid_reg;
    end else if (load) begin
      pcinc_reg <= pcinc_in;
      instr_reg <= instr_in;
      valid_reg <= 1'b1;
    end else begin
      pcinc_reg <= '0;
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end
  end

  assign PCIncOUT       = pcinc_reg;
  assign InstructionOUT = instr_reg;
  assign validOUT       = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the fetch FSM, drives the icache
// request and feeds the IF/ID latch that decode reads directly.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] PCIncOUT,
  output logic [31:0] InstructionOUT,
  output logic        validOUT
);

  fetch_state_t state_reg;
  word_t        pc_reg;
  word_t        pending_pc_reg;
  logic         imemren_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= FETCH;
      pc_reg         <= PC_INIT;
      pending_pc_reg <= '0;
      imemren_reg    <= 1'b1;
    end else if (halt) begin
      state_reg   <= HALTED;
      imemren_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          imemren_reg <= 1'b1;
          if (redirect) begin
            if (ihit) begin
              pc_reg <= redirect_pc;
            end else begin
              // The miss for the old PC is still outstanding; keep its address
              // on the bus until the icache answers, then jump.
              pending_pc_reg <= redirect_pc;
              state_reg      <= DRAIN;
            end
          end else if (ihit && !stall) begin
            pc_reg <= pc_inc(pc_reg);
          end
        end
        DRAIN: begin
          imemren_reg <= 1'b1;
          if (ihit) begin
            pc_reg    <= redirect ? redirect_pc : pending_pc_reg;
            state_reg <= FETCH;
          end else if (redirect) begin
            pending_pc_reg <= redirect_pc;
          end
        end
        HALTED: begin
          imemren_reg <= 1'b0;
        end
        default: begin
          state_reg   <= FETCH;
          imemren_reg <= 1'b1;
        end
      endcase
    end
  end

  assign imemREN  = imemren_reg;
  assign imemaddr = pc_reg;

  logic latch_flush;
  logic latch_load;

  // Words returned while draining a redirected miss are never latched.
  assign latch_flush = halt | redirect;
  assign latch_load  = (state_reg == FETCH) && ihit;

  fetch_registers #(
    .NOP_INSTR(NOP_INSTR)
  ) u_fetch_registers (
    .CLK           (CLK),
    .nRST          (nRST),
    .flush         (latch_flush),
    .hold          (stall),
    .load          (latch_load),
    .pcinc_in      (pc_inc(pc_reg)),
    .instr_in      (imemload),
    .PCIncOUT      (PCIncOUT),
    .InstructionOUT(InstructionOUT),
    .validOUT      (validOUT)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected latched
// {PC+4, instr} pairs; a monitor pops and compares whenever validOUT shows new data.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] PCIncOUT;
  logic [31:0] InstructionOUT;
  logic        validOUT;

  fetch_stage dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ihit          (ihit),
    .imemload      (imemload),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .PCIncOUT      (PCIncOUT),
    .InstructionOUT(InstructionOUT),
    .validOUT      (validOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   total_checks = 0;
  int   passed_checks = 0;
  int   step_no = 0;
  logic held_edge = 1'b0;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_checks++;
    if (act === req) passed_checks++;
    else $display("FAIL %s (step %0d): got %h, expected %h", name, step_no, act, req);
  endtask

  // Latch legitimately holds old data on an edge with stall and no flush.
  always @(posedge CLK) held_edge = stall && !redirect && !halt;

  always @(negedge CLK) begin
    exp_t e;
    if (nRST && validOUT && !held_edge) begin
      if (sb_q.size() == 0) begin
        total_checks++;
        $display("FAIL sb_unexpected (step %0d): got instr %h pc4 %h, expected none",
                 step_no, InstructionOUT, PCIncOUT);
      end else begin
        e = sb_q.pop_front();
        check("sb_pcinc", PCIncOUT, e.pc4);
        check("sb_instr", InstructionOUT, e.instr);
        $display("latched instr %h pc4 %h", InstructionOUT, PCIncOUT);
      end
    end
  end

  // One clock of stimulus: checks the request before the edge, queues the
  // expected latch contents, then checks validOUT (and bubble contents) after it.
  task automatic step(input logic ih, input logic [31:0] ld, input logic st,
                      input logic rd, input logic [31:0] rpc, input logic hl,
                      input logic [31:0] eaddr, input logic eren,
                      input logic push, input logic [31:0] epc4, input logic ev);
    exp_t e;
    step_no++;
    ihit = ih; imemload = ld; stall = st; redirect = rd; redirect_pc = rpc; halt = hl;
    #1;
    check("imemaddr", imemaddr, eaddr);
    check("imemREN", {31'b0, imemREN}, {31'b0, eren});
    $display("step %0d addr %h ren %0d ihit %0d stall %0d redir %0d halt %0d",
             step_no, imemaddr, imemREN, ih, st, rd, hl);
    if (push) begin
      e.pc4 = epc4; e.instr = ld;
      sb_q.push_back(e);
    end
    @(posedge CLK);
    @(negedge CLK);
    check("validOUT", {31'b0, validOUT}, {31'b0, ev});
    if (!ev) begin
      check("bubble_instr", InstructionOUT, NOP_WORD);
      check("bubble_pcinc", PCIncOUT, 32'h0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, imemaddr, 32'h0);
    check({tag, "_valid"}, {31'b0, validOUT}, 32'h0);
    check({tag, "_instr"}, InstructionOUT, NOP_WORD);
    check({tag, "_pcinc"}, PCIncOUT, 32'h0);
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; imemload = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    @(negedge CLK); @(negedge CLK);
    check_reset_values("reset");
    nRST = 1'b1;
    #1;
    check("reset_ren", {31'b0, imemREN}, 32'h1);

    // sequential fetch
    step(1, ins(32'h0),  0, 0, 0, 0, 32'h0,  1, 1, 32'h4,  1);
    step(1, ins(32'h4),  0, 0, 0, 0, 32'h4,  1, 1, 32'h8,  1);
    // three misses at 8
    step(0, 32'h0,       0, 0, 0, 0, 32'h8,  1, 0, 0,      0);
    step(0, 32'h0,       0, 0, 0, 0, 32'h8,  1, 0, 0,      0);
    step(0, 32'h0,       0, 0, 0, 0, 32'h8,  1, 0, 0,      0);
    step(1, ins(32'h8),  0, 0, 0, 0, 32'h8,  1, 1, 32'hC,  1);
    step(1, ins(32'hC),  0, 0, 0, 0, 32'hC,  1, 1, 32'h10, 1);
    // stall two cycles at 0x10 with ihit
    step(1, ins(32'h10), 1, 0, 0, 0, 32'h10, 1, 0, 0,      1);
    check("stall_hold_pcinc", PCIncOUT, 32'h10);
    step(1, ins(32'h10), 1, 0, 0, 0, 32'h10, 1, 0, 0,      1);
    check("stall_hold_instr", InstructionOUT, ins(32'hC));
    step(1, ins(32'h10), 0, 0, 0, 0, 32'h10, 1, 1, 32'h14, 1);
    // redirect on hit
    step(1, ins(32'h14), 0, 1, 32'h40, 0, 32'h14, 1, 0, 0, 0);
    step(1, ins(32'h40), 0, 0, 0, 0, 32'h40, 1, 1, 32'h44, 1);
    step(1, ins(32'h44), 0, 1, 32'h20, 0, 32'h44, 1, 0, 0, 0);
    // redirect on miss: drain 0x20, drop the returned word
    step(0, 32'h0,        0, 1, 32'h40, 0, 32'h20, 1, 0, 0, 0);
    step(0, 32'h0,        0, 0, 0,      0, 32'h20, 1, 0, 0, 0);
    step(1, 32'hDEADBEEF, 0, 0, 0,      0, 32'h20, 1, 0, 0, 0);
    step(1, ins(32'h40),  0, 0, 0,      0, 32'h40, 1, 1, 32'h44, 1);
    // double redirect while draining
    step(0, 32'h0,       0, 1, 32'h80, 0, 32'h44, 1, 0, 0, 0);
    step(0, 32'h0,       0, 1, 32'h90, 0, 32'h44, 1, 0, 0, 0);
    step(1, ins(32'h44), 0, 0, 0,      0, 32'h44, 1, 0, 0, 0);
    step(1, ins(32'h90), 0, 0, 0,      0, 32'h90, 1, 1, 32'h94, 1);
    // redirect and stall together: redirect wins
    step(1, ins(32'h94), 1, 1, 32'hC0, 0, 32'h94, 1, 0, 0, 0);
    step(1, ins(32'hC0), 0, 0, 0,      0, 32'hC0, 1, 1, 32'hC4, 1);
    // PC+4 wrap
    step(1, ins(32'hC4), 0, 1, 32'hFFFF_FFFC, 0, 32'hC4, 1, 0, 0, 0);
    step(1, ins(32'hFFFF_FFFC), 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 32'h0, 1);
    // halt during a miss
    step(0, 32'h0,      0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0,      0, 0, 0, 1, 32'h0, 1, 0, 0, 0);
    step(1, ins(32'h0), 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    step(1, ins(32'h0), 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    // reset leaves HALTED
    nRST = 1'b0;
    @(negedge CLK);
    check_reset_values("halt_reset");
    nRST = 1'b1;
    step(1, ins(32'h0), 0, 0, 0, 0, 32'h0, 1, 1, 32'h4, 1);
    step(0, 32'h0,      0, 1, 32'h100, 0, 32'h4, 1, 0, 0, 0);
    // asynchronous reset in the middle of DRAIN
    ihit = 1'b0; redirect = 1'b0;
    #2 nRST = 1'b0;
    #1;
    check_reset_values("drain_reset");
    check("drain_reset_ren", {31'b0, imemREN}, 32'h1);
    @(negedge CLK);
    nRST = 1'b1;
    step(1, ins(32'h0), 0, 0, 0, 0, 32'h0, 1, 1, 32'h4, 1);
    step(1, ins(32'h4), 0, 0, 0, 0, 32'h4, 1, 1, 32'h8, 1);
    step(0, 32'h0,      0, 0, 0, 0, 32'h8, 1, 0, 0, 0);
    step(0, 32'h0,      0, 0, 0, 0, 32'h8, 1, 0, 0, 0);

    check("sb_leftover", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
